fetch_ifid: RTL and testbench
=============================

Name: fetch_ifid

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the hazard unit.
- Generates the PC and issues instruction-memory requests with a ready handshake.
- Presents {pc, instr, valid} to decode and consumes the hazard unit's stall (nop) and the branch flush/redirect.
- Holds or buffers a returning instruction while decode is stalled, so no fetch is lost or duplicated.

Parameters:
- XLEN, 32, PC/address width.
- ILEN, 32, instruction width.
- RESET_PC, 32'h0000_1000, PC loaded on reset.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_nop  in  1  stall from hazard unit; decode must hold.
- i_flush  in  1  discard the fetch path and redirect.
- i_redirect_pc  in  XLEN  new PC on flush; bits [1:0] forced to 0.
- o_mem_req  out  1  instruction-memory request.
- o_mem_addr  out  XLEN  request address (= pc).
- i_mem_ready  in  1  response valid this cycle (req && ready = transfer).
- i_mem_instr  in  ILEN  instruction data, valid when i_mem_ready.
- o_pc_1  out  XLEN  IF/ID pc.
- o_instr_1  out  ILEN  IF/ID instruction.
- o_valid_1  out  1  IF/ID entry valid.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=BOOT, buf_valid=0, o_valid_1=0, o_pc_1=0, o_instr_1=NOP_INSTR.
- States BOOT, FETCH, HELD. o_mem_req=1 only in FETCH. o_mem_addr=pc at all times.
- BOOT: one cycle with no request, then FETCH. i_flush in BOOT loads the redirect PC and still goes to FETCH.
- FETCH, transfer and !i_nop:
  - IF/ID <= {pc, i_mem_instr, 1}.
  - pc <= pc+4.
  - Latency: request cycle to IF/ID valid is one edge.
- FETCH, transfer and i_nop:
  - IF/ID holds.
  - buffer <= {pc, i_mem_instr}.
  - pc <= pc+4.
  - state <= HELD.
- FETCH, no transfer:
  - !i_nop: IF/ID <= bubble {0, NOP_INSTR, valid 0}.
  - i_nop: IF/ID holds.
- HELD:
  - No request while i_nop=1; IF/ID holds.
  - On the first cycle with i_nop=0: IF/ID <= {buffer, 1}, buf_valid <= 0, state <= FETCH.
  - The next request issues the following cycle.
- i_flush has highest priority over i_nop and any transfer in the same cycle:
  - pc <= {i_redirect_pc[XLEN-1:2], 2'b00}.
  - IF/ID <= bubble; buffer discarded; state <= FETCH.
  - A same-cycle memory response is dropped.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 wraps to 0, no flag.
- A stall never drops or duplicates an instruction: each transferred pc appears in IF/ID exactly once with valid=1, unless flushed.
- Reset mid-HELD or mid-request: all state returns to reset values immediately; a pending response is ignored.

Decomposition:
- Shared package cl_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - PC_STEP = 4.
  - fetch_state_t enum {BOOT, FETCH, HELD}.
  - ifid_t struct {pc, instr, valid}.
- Sub-module ifid_reg:
  - Holds an ifid_t.
  - Inputs i_en (load), i_bubble (clear to NOP, valid 0), async reset.
  - i_bubble dominates i_en.
  - Reused later for ID/EX.

Test Plan:
- Reset release, i_mem_ready=1 always, i_nop=0 -> BOOT one cycle (o_mem_req=0), then addresses 0x1000, 0x1004, 0x1008 on consecutive cycles; IF/ID shows each pc one edge later, valid=1.
- i_mem_ready=0 for 2 cycles at pc 0x1004 -> o_valid_1=0 for 2 cycles, then {0x1004, instr, 1}; pc does not advance while waiting.
- Transfer at 0x1008 with i_nop=1 for 3 cycles -> IF/ID holds 0x1004; state HELD with o_mem_req=0. After i_nop falls, IF/ID={0x1008, instr, 1} and the next request is 0x100C.
- i_flush with i_redirect_pc=0x2003 while i_nop=1 and a transfer in the same cycle -> IF/ID valid=0, the response is dropped, the next o_mem_addr is 0x2000, and 0x2000 is the next valid IF/ID entry.
- pc=0xFFFF_FFFC, transfer -> next o_mem_addr=0x0000_0000.
- Assert i_rst while in HELD -> outputs immediately read valid=0, instr=0x13, pc=0; the first request after release is 0x1000.

Source files
------------

// File: rtl/cl_pkg.sv
// Shared types and constants for the fetch front end and its pipeline registers.
// The IF/ID record is sized by CL_XLEN/CL_ILEN; modules cast to their own widths.
package cl_pkg;

   localparam int unsigned CL_XLEN = 32;
   localparam int unsigned CL_ILEN = 32;

   localparam logic [CL_ILEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam int unsigned        PC_STEP   = 4;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HELD  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [CL_XLEN-1:0] pc;
      logic [CL_ILEN-1:0] instr;
      logic               valid;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

   // Word-align a redirect target by clearing the two low address bits.
   function automatic logic [CL_XLEN-1:0] align_pc(input logic [CL_XLEN-1:0] a);
      return {a[CL_XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register holding one ifid_t record; bubble clears to a NOP with
// valid low and takes precedence over a load in the same cycle.
module ifid_reg
   import cl_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_rst,
   input  logic  i_en,
   input  logic  i_bubble,
   input  ifid_t i_d,
   output ifid_t o_q
);

   ifid_t r_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q <= IFID_BUBBLE;
      end else if (i_bubble) begin
         r_q <= IFID_BUBBLE;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/fetch_ifid.sv
// Instruction-fetch stage with IF/ID register: PC generation, memory request
// handshake, and a one-entry buffer that parks a fetch while decode stalls.
module fetch_ifid
   import cl_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     ILEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_1000
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_nop,
   input  logic            i_flush,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_mem_req,
   output logic [XLEN-1:0] o_mem_addr,
   input  logic            i_mem_ready,
   input  logic [ILEN-1:0] i_mem_instr,
   output logic [XLEN-1:0] o_pc_1,
   output logic [ILEN-1:0] o_instr_1,
   output logic            o_valid_1
);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_mem_req;
   logic            r_buf_valid;
   logic [XLEN-1:0] r_buf_pc;
   logic [ILEN-1:0] r_buf_instr;

   logic            w_xfer;
   logic [XLEN-1:0] w_pc_next;
   logic [XLEN-1:0] w_redirect;
   logic            w_en;
   logic            w_bubble;
   ifid_t           w_d;
   ifid_t           w_q;

   assign w_xfer     = r_mem_req & i_mem_ready;
   assign w_pc_next  = r_pc + XLEN'(PC_STEP);
   assign w_redirect = XLEN'(align_pc(CL_XLEN'(i_redirect_pc)));

   // o_mem_req is kept as its own register, updated alongside the state so
   // it is glitch-free and equals (state == FETCH) at every edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= BOOT;
         r_pc        <= RESET_PC;
         r_mem_req   <= 1'b0;
         r_buf_valid <= 1'b0;
         r_buf_pc    <= '0;
         r_buf_instr <= ILEN'(NOP_INSTR);
      end else if (i_flush) begin
         r_state     <= FETCH;
         r_pc        <= w_redirect;
         r_mem_req   <= 1'b1;
         r_buf_valid <= 1'b0;
      end else begin
         unique case (r_state)
            BOOT: begin
               r_state   <= FETCH;
               r_mem_req <= 1'b1;
            end
            FETCH: begin
               if (w_xfer) begin
                  r_pc <= w_pc_next;
                  if (i_nop) begin
                     r_buf_valid <= 1'b1;
                     r_buf_pc    <= r_pc;
                     r_buf_instr <= i_mem_instr;
                     r_state     <= HELD;
                     r_mem_req   <= 1'b0;
                  end
               end
            end
            HELD: begin
               if (!i_nop) begin
                  r_buf_valid <= 1'b0;
                  r_state     <= FETCH;
                  r_mem_req   <= 1'b1;
               end
            end
            default: begin
               r_state   <= BOOT;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_en     = 1'b0;
      w_bubble = 1'b0;
      w_d      = IFID_BUBBLE;
      if (i_flush) begin
         w_bubble = 1'b1;
      end else if (r_state == HELD) begin
         w_en = ~i_nop;
      end else if (r_state == FETCH) begin
         w_en     = w_xfer & ~i_nop;
         w_bubble = ~w_xfer & ~i_nop;
      end
      if (r_buf_valid) begin
         w_d.pc    = CL_XLEN'(r_buf_pc);
         w_d.instr = CL_ILEN'(r_buf_instr);
      end else begin
         w_d.pc    = CL_XLEN'(r_pc);
         w_d.instr = CL_ILEN'(i_mem_instr);
      end
      w_d.valid = 1'b1;
   end

   ifid_reg u_ifid (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_en     (w_en),
      .i_bubble (w_bubble),
      .i_d      (w_d),
      .o_q      (w_q)
   );

   assign o_mem_req  = r_mem_req;
   assign o_mem_addr = r_pc;
   assign o_pc_1     = XLEN'(w_q.pc);
   assign o_instr_1  = ILEN'(w_q.instr);
   assign o_valid_1  = w_q.valid;

endmodule

// File: tb/tb_fetch_ifid.sv
// Randomized bench for fetch_ifid against a queue-based fetch model,
// preceded by directed boot, wait, stall, flush, wrap and reset sequences.
module tb_fetch_ifid;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_nop = 1'b0;
   logic        i_flush = 1'b0;
   logic [31:0] i_redirect_pc = '0;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        i_mem_ready = 1'b0;
   logic [31:0] i_mem_instr = '0;
   logic [31:0] o_pc_1;
   logic [31:0] o_instr_1;
   logic        o_valid_1;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   fetch_ifid #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0000_1000)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_nop         (i_nop),
      .i_flush       (i_flush),
      .i_redirect_pc (i_redirect_pc),
      .o_mem_req     (o_mem_req),
      .o_mem_addr    (o_mem_addr),
      .i_mem_ready   (i_mem_ready),
      .i_mem_instr   (i_mem_instr),
      .o_pc_1        (o_pc_1),
      .o_instr_1     (o_instr_1),
      .o_valid_1     (o_valid_1)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish, observed timeout, required completion");
      $fatal(1, "watchdog");
   end

   // Reference model: a boot flag, the next fetch address, and a queue of
   // fetched-but-not-yet-delivered instructions (a request goes out only
   // when not booting and nothing is parked).
   bit          m_booting;
   logic [31:0] m_pc;
   logic [63:0] m_parked[$];
   logic [31:0] m_id_pc, m_id_instr;
   logic        m_id_valid;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h, required %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_booting  = 1'b1;
      m_pc       = 32'h0000_1000;
      m_parked.delete();
      m_id_pc    = 32'h0;
      m_id_instr = 32'h13;
      m_id_valid = 1'b0;
   endtask

   function automatic bit model_req();
      return !m_booting && (m_parked.size() == 0);
   endfunction

   task automatic model_bubble();
      m_id_pc    = 32'h0;
      m_id_instr = 32'h13;
      m_id_valid = 1'b0;
   endtask

   task automatic model_edge(input logic nop, input logic flush, input logic [31:0] redir,
                             input logic ready, input logic [31:0] instr);
      bit req;
      req = model_req();
      if (flush) begin
         m_pc      = redir - (redir % 4);
         m_booting = 1'b0;
         m_parked.delete();
         model_bubble();
      end else if (m_booting) begin
         m_booting = 1'b0;
      end else if (m_parked.size() != 0) begin
         if (!nop) begin
            m_id_pc    = m_parked[0][63:32];
            m_id_instr = m_parked[0][31:0];
            m_id_valid = 1'b1;
            void'(m_parked.pop_front());
         end
      end else if (req && ready) begin
         if (nop) begin
            m_parked.push_back({m_pc, instr});
         end else begin
            m_id_pc    = m_pc;
            m_id_instr = instr;
            m_id_valid = 1'b1;
         end
         m_pc = m_pc + 32'd4;
      end else if (!nop) begin
         model_bubble();
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".req"},   {31'b0, o_mem_req}, {31'b0, model_req()});
      check({tag, ".addr"},  o_mem_addr,         m_pc);
      check({tag, ".pc1"},   o_pc_1,             m_id_pc);
      check({tag, ".instr1"}, o_instr_1,         m_id_instr);
      check({tag, ".valid1"}, {31'b0, o_valid_1}, {31'b0, m_id_valid});
   endtask

   // Called at a falling edge: drive inputs, advance one clock, then compare.
   task automatic step(input string tag, input logic nop, input logic flush,
                       input logic [31:0] redir, input logic ready, input logic [31:0] instr);
      i_nop         = nop;
      i_flush       = flush;
      i_redirect_pc = redir;
      i_mem_ready   = ready;
      i_mem_instr   = instr;
      @(posedge i_clk);
      model_edge(nop, flush, redir, ready, instr);
      @(negedge i_clk);
      compare_all(tag);
   endtask

   task automatic do_reset(input string tag);
      i_rst = 1'b1;
      #1;
      model_reset();
      compare_all({tag, ".async"});
      @(negedge i_clk);
      i_rst = 1'b0;
      compare_all({tag, ".rel"});
   endtask

   initial begin
      logic [31:0] ins;
      model_reset();
      repeat (2) @(negedge i_clk);
      compare_all("por");
      i_rst = 1'b0;
      check("boot_req", {31'b0, o_mem_req}, 32'h0);

      // Boot then back-to-back fetches.
      step("boot", 1'b0, 1'b0, 32'h0, 1'b1, $urandom);
      check("first_addr", o_mem_addr, 32'h0000_1000);
      for (int i = 0; i < 3; i++) step("seq", 1'b0, 1'b0, 32'h0, 1'b1, $urandom);
      check("seq_pc1", o_pc_1, 32'h0000_1008);

      // Memory wait at 0x1004.
      do_reset("rst_a");
      step("boot2", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
      step("x1000", 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0001);
      step("wait0", 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
      step("wait1", 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
      check("wait_valid", {31'b0, o_valid_1}, 32'h0);
      check("wait_addr", o_mem_addr, 32'h0000_1004);
      step("x1004", 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0002);
      check("x1004_pc1", o_pc_1, 32'h0000_1004);

      // Stall while 0x1008 transfers: parked for three cycles, then delivered.
      step("stall0", 1'b1, 1'b0, 32'h0, 1'b1, 32'hA000_0003);
      step("stall1", 1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0_0000);
      step("stall2", 1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0_0000);
      check("held_pc1", o_pc_1, 32'h0000_1004);
      check("held_req", {31'b0, o_mem_req}, 32'h0);
      step("unstall", 1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0000);
      check("unstall_pc1", o_pc_1, 32'h0000_1008);
      check("unstall_instr", o_instr_1, 32'hA000_0003);
      check("unstall_addr", o_mem_addr, 32'h0000_100C);

      // Flush beats stall and a same-cycle transfer.
      step("flush", 1'b1, 1'b1, 32'h0000_2003, 1'b1, 32'hBAD0_0001);
      check("flush_addr", o_mem_addr, 32'h0000_2000);
      step("x2000", 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_2000);
      check("x2000_pc1", o_pc_1, 32'h0000_2000);

      // PC wrap.
      step("wrapf", 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0);
      step("wrapx", 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_FFFC);
      check("wrap_addr", o_mem_addr, 32'h0000_0000);

      // Reset asserted while parked.
      step("hold_in", 1'b1, 1'b0, 32'h0, 1'b1, 32'hA000_0009);
      check("pre_rst_req", {31'b0, o_mem_req}, 32'h0);
      do_reset("rst_held");
      check("rst_instr", o_instr_1, 32'h0000_0013);
      step("boot3", 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
      check("post_rst_addr", o_mem_addr, 32'h0000_1000);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         logic [31:0] redir;
         if ($urandom_range(0, 299) == 0) begin
            do_reset("rnd_rst");
         end else begin
            redir = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            ins = $urandom;
            step("rnd", ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 5),
                 redir, ($urandom_range(0, 99) < 70), ins);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
